// File: rtl/muldiv_iter.sv
// muldiv_iter -- iterative integer multiply / divide unit.
//
// One operand bit is processed per cycle: radix-2 shift-add for multiply and
// restoring division for divide. Both work on operand magnitudes. The sign
// correction is applied on the cycle that enters DONE.
//
// Optional feature macro: MULDIV_ITER_DIV_EN
//   defined   : the divider is built (quotient in lo_o, remainder in hi_o).
//   undefined : no divider logic. An op_i=1 request goes straight to DONE
//               and returns hi_o = lo_o = 0.
//
// Ports
//   clk       in   sole clock, rising edge
//   reset     in   asynchronous, active-high
//   valid_i   in   request present
//   op_i      in   0 = multiply, 1 = divide
//   signed_i  in   1 = two's complement operands, 0 = unsigned
//   a_i       in   multiplicand / dividend
//   b_i       in   multiplier / divisor
//   flush_i   in   abort the operation in flight (blocks any accept)
//   ready_o   out  request can be accepted this cycle (IDLE or DONE)
//   done_o    out  one-cycle pulse while in DONE
//   hi_o      out  product upper half / remainder
//   lo_o      out  product lower half / quotient
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic             op_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // Shared working register.
    //   multiply: {partial product, multiplier}
    //   divide:   {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] acc_q, acc_d;
    // Operand magnitude: multiplicand for multiply, divisor for divide.
    logic [WIDTH-1:0]   m_q, m_d;
    // Negate the product or quotient at the end.
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
`ifdef MULDIV_ITER_DIV_EN
    logic               op_q, op_d;
    logic               rem_neg_q, rem_neg_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
`endif

    logic               accept;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] step_res;
    logic [2*WIDTH-1:0] fin;

    assign ready_o = (state_q != RUN);
    assign done_o  = (state_q == DONE);
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

    assign accept = valid_i && ready_o && !flush_i;
    assign a_neg  = signed_i & a_i[WIDTH-1];
    assign b_neg  = signed_i & b_i[WIDTH-1];
    // The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which still fits in WIDTH
    // unsigned bits.
    assign a_mag  = a_neg ? -a_i : a_i;
    assign b_mag  = b_neg ? -b_i : b_i;

    // Shift-add step. The carry out of the add shifts into the top bit.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

`ifdef MULDIV_ITER_DIV_EN
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    // Restoring step. The shifted remainder is below 2*divisor, so one extra
    // bit is enough for the compare. A successful subtract leaves a result
    // that fits back in WIDTH bits.
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign trial    = rem_sh - {1'b0, m_q};
    assign div_next = (rem_sh >= {1'b0, m_q})
                    ? {trial[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1}
                    : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    assign step_res = op_q ? div_next : mul_next;
    assign quo      = step_res[WIDTH-1:0];
    assign rem      = step_res[2*WIDTH-1:WIDTH];

    // Divide by zero returns the raw dividend with no sign fix-up.
    // -2^(W-1) / -1 needs no special case: the quotient magnitude 2^(W-1)
    // already reads back as -2^(W-1).
    always_comb begin
        if (!op_q)
            fin = neg_q ? ('0 - step_res) : step_res;
        else if (dz_q)
            fin = {a_raw_q, {WIDTH{1'b1}}};
        else
            fin = {rem_neg_q ? -rem : rem, neg_q ? -quo : quo};
    end
`else
    assign step_res = mul_next;
    assign fin      = neg_q ? ('0 - step_res) : step_res;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        m_d     = m_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MULDIV_ITER_DIV_EN
        op_d      = op_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        a_raw_d   = a_raw_q;
`endif

        unique case (state_q)
            IDLE: ;
            RUN: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    acc_d = step_res;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d      = DONE;
                        {hi_d, lo_d} = fin;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // An accept can only happen in IDLE or DONE. It overrides the default
        // next state above, which gives the back-to-back DONE -> RUN path.
        if (accept) begin
            cnt_d   = '0;
            neg_d   = a_neg ^ b_neg;
            acc_d   = op_i ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
            m_d     = op_i ? b_mag : a_mag;
            state_d = RUN;
`ifdef MULDIV_ITER_DIV_EN
            op_d      = op_i;
            rem_neg_d = a_neg;
            dz_d      = (b_i == '0);
            a_raw_d   = a_i;
`else
            if (op_i) begin
                state_d = DONE;
                hi_d    = '0;
                lo_d    = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            m_q     <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

`ifdef MULDIV_ITER_DIV_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            a_raw_q   <= '0;
        end else begin
            op_q      <= op_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            a_raw_q   <= a_raw_d;
        end
    end
`endif

endmodule

// File: tb/tb_muldiv_iter.sv
// Testbench for muldiv_iter (WIDTH=32): directed corner cases plus random
// operations checked against an arithmetic reference model.
module tb_muldiv_iter;

`ifdef MULDIV_ITER_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, valid_i, op_i, signed_i, flush_i;
    logic [31:0] a_i, b_i;
    logic        ready_o, done_o;
    logic [31:0] hi_o, lo_o;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] prev = 64'd0;

    muldiv_iter #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .op_i(op_i),
        .signed_i(signed_i), .a_i(a_i), .b_i(b_i), .flush_i(flush_i),
        .ready_o(ready_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference result {hi, lo}, from plain integer arithmetic.
    function automatic logic [63:0] model(input logic op, input logic sg,
                                          input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = sg ? longint'($signed(a)) : longint'({32'd0, a});
        sb = sg ? longint'($signed(b)) : longint'({32'd0, b});
        if (!op) return 64'(sa * sb);
        if (!DIV_EN) return 64'd0;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {32'(sa % sb), 32'(sa / sb)};
    endfunction

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 3));
            default: return $urandom();
        endcase
    endfunction

    // Call at a negedge with ready_o expected high. Returns at the negedge of
    // the DONE cycle.
    task automatic run_op(input logic op, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input string tag);
        logic [63:0] exp;
        int          lat, exp_lat;
        exp     = model(op, sg, a, b);
        exp_lat = (op && !DIV_EN) ? 1 : 33;
        chk({tag, "_ready"}, 64'(ready_o), 64'd1);
        valid_i = 1'b1; op_i = op; signed_i = sg; a_i = a; b_i = b;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0; a_i = $urandom(); b_i = $urandom(); signed_i = $urandom_range(0, 1);
        lat = 1;
        while (done_o !== 1'b1 && lat < 100) begin
            if (lat == 2) begin
                chk({tag, "_busy"}, 64'(ready_o), 64'd0);
                chk({tag, "_hold"}, {hi_o, lo_o}, prev);
            end
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_hi"}, 64'(hi_o), 64'(exp[63:32]));
        chk({tag, "_lo"}, 64'(lo_o), 64'(exp[31:0]));
        prev = exp;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_done", 64'(done_o), 64'd0);
            chk("idle_ready", 64'(ready_o), 64'd1);
        end
    endtask

    initial begin
        logic saw;
        reset = 1'b1; valid_i = 1'b0; op_i = 1'b0; signed_i = 1'b0; flush_i = 1'b0;
        a_i = 32'd0; b_i = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(ready_o), 64'd1);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_out", {hi_o, lo_o}, 64'd0);
        reset = 1'b0;

        // Accepted on the first edge after reset is released.
        run_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0002, "smul_m1x2");
        idle(2);
        run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "umul_max");
        idle(1);
        run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, "sdiv_m7_2");
        run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "sdiv_ovf");
        idle(1);
        run_op(1'b1, 1'b0, 32'h1234_5678, 32'h0000_0000, "udiv_zero");
        idle(1);
        run_op(1'b1, 1'b1, 32'h8765_4321, 32'h0000_0000, "sdiv_zero");
        idle(1);
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, "smul_min");
        idle(1);

        for (int k = 0; k < 24; k++) begin
            int gap;
            run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   rnd_opnd(), rnd_opnd(), "rand");
            gap = $urandom_range(0, 2);
            if (gap > 0) idle(gap);
        end
        idle(1);

        // Flush during RUN cycle 10.
        valid_i = 1'b1; op_i = 1'b0; signed_i = 1'b0; a_i = 32'd12345; b_i = 32'd678;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        for (int c = 1; c < 10; c++) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        chk("flush_run_ready", 64'(ready_o), 64'd1);
        chk("flush_run_done", 64'(done_o), 64'd0);
        chk("flush_run_out", {hi_o, lo_o}, prev);
        saw = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done_o) saw = 1'b1;
        end
        chk("flush_run_nodone", 64'(saw), 64'd0);

        // A new request accepted in DONE.
        run_op(1'b0, 1'b0, 32'd3, 32'd5, "b2b_a");
        run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7, "b2b_b");

        // Flush in DONE blocks the accept and the FSM returns to IDLE.
        valid_i = 1'b1; op_i = 1'b0; signed_i = 1'b0; a_i = 32'd9; b_i = 32'd9;
        flush_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0; flush_i = 1'b0;
        chk("flush_done_ready", 64'(ready_o), 64'd1);
        chk("flush_done_done", 64'(done_o), 64'd0);
        chk("flush_done_out", {hi_o, lo_o}, prev);
        idle(2);

        // Reset pulsed in the middle of RUN.
        valid_i = 1'b1; op_i = 1'b0; signed_i = 1'b0; a_i = 32'hDEAD_BEEF; b_i = 32'h1234;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_run_out", {hi_o, lo_o}, 64'd0);
        chk("rst_run_done", 64'(done_o), 64'd0);
        chk("rst_run_ready", 64'(ready_o), 64'd1);
        prev = 64'd0;
        @(negedge clk);
        reset = 1'b0;
        saw = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done_o) saw = 1'b1;
        end
        chk("rst_run_nodone", 64'(saw), 64'd0);
        run_op(1'b0, 1'b0, 32'd1000, 32'd1000, "post_rst");
        idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_iter.md
MULDIV_ITER -- requirements
Module: muldiv_iter

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; legal values are even numbers 8..64.
REQ-002 Port clk, input, 1 bit, sole clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit, asynchronous, active-high reset.
REQ-004 Port valid_i, input, 1 bit, request present this cycle.
REQ-005 Port op_i, input, 1 bit, operation select: 0 = multiply, 1 = divide.
REQ-006 Port signed_i, input, 1 bit, operands are two's complement when 1 and unsigned when 0.
REQ-007 Port a_i, input, WIDTH bits, multiplicand or dividend.
REQ-008 Port b_i, input, WIDTH bits, multiplier or divisor.
REQ-009 Port flush_i, input, 1 bit, abort any operation in flight.
REQ-010 Port ready_o, output, 1 bit, unit can accept a request this cycle.
REQ-011 Port done_o, output, 1 bit, one-cycle pulse when a result becomes valid.
REQ-012 Port hi_o, output, WIDTH bits, product upper half, or remainder on divide.
REQ-013 Port lo_o, output, WIDTH bits, product lower half, or quotient on divide.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 ready_o SHALL be 1 in IDLE and DONE and 0 in RUN.
REQ-016 A request SHALL be accepted on a rising edge where valid_i=1, ready_o=1 and flush_i=0; the operands, op_i and signed_i are latched on that edge and the FSM enters RUN.
REQ-017 In RUN the unit SHALL process one operand bit per cycle (radix-2 shift-add multiply; restoring divide on magnitudes) for exactly WIDTH cycles, then enter DONE.
REQ-018 done_o SHALL be 1 only in the single cycle spent in DONE, i.e. exactly WIDTH+1 cycles after the accepting edge.
REQ-019 hi_o and lo_o SHALL update only on entry to DONE and SHALL hold until the next DONE entry.
REQ-020 An accept while in DONE SHALL move the FSM directly to RUN (back-to-back operation); with no accept, DONE SHALL return to IDLE.
REQ-021 Multiply: {hi_o, lo_o} SHALL be the full 2*WIDTH-bit product, signed or unsigned as signed_i selects.
REQ-022 Signed multiply/divide SHALL operate on magnitudes; the product and quotient are negated when the operand signs differ, and the remainder takes the sign of the dividend.
REQ-023 Divide by zero SHALL give lo_o = all ones and hi_o = a_i as latched, with no sign correction, and SHALL take the normal latency.
REQ-024 Signed divide of -2^(WIDTH-1) by -1 SHALL give lo_o = -2^(WIDTH-1) and hi_o = 0.
REQ-025 flush_i=1 in RUN SHALL return the FSM to IDLE on the next edge with no done_o pulse and no change to hi_o or lo_o.
REQ-026 flush_i=1 in DONE SHALL still let done_o pulse that cycle, SHALL block any accept, and the FSM SHALL go to IDLE.
REQ-027 valid_i while ready_o=0 SHALL be ignored; the requester holds the request until it is accepted.

Reset
REQ-028 Asserting reset SHALL immediately force the FSM to IDLE and clear done_o, hi_o, lo_o and all internal registers to 0, including during an operation in RUN.
REQ-029 The first accept SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-030 When macro MULDIV_ITER_DIV_EN is defined, divide SHALL be implemented as in REQ-017 to REQ-024.
REQ-031 When MULDIV_ITER_DIV_EN is not defined, no divider logic is built; an op_i=1 request is accepted, goes IDLE->DONE without RUN (done_o one cycle after accept), and returns hi_o = lo_o = 0.

Verification (WIDTH=32)
REQ-032 Signed multiply 0xFFFFFFFF x 0x00000002 -> done_o at cycle 33 after accept, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFE.
REQ-033 Unsigned multiply 0xFFFFFFFF x 0xFFFFFFFF -> hi_o=0xFFFFFFFE, lo_o=0x00000001.
REQ-034 Signed divide -7/2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; then 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
REQ-035 Divide 0x12345678/0 -> lo_o=0xFFFFFFFF, hi_o=0x12345678.
REQ-036 flush_i at RUN cycle 10 -> no done_o, hi_o/lo_o unchanged, ready_o=1 next cycle; a new request accepted in DONE -> its done_o 33 cycles later.
REQ-037 reset pulsed mid-RUN -> outputs 0 immediately, ready_o=1, no done_o afterwards.
